// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : axis_arb_pkg
// Purpose: Shared types and default constants for the AXI-Stream
//          round-robin arbiter (FSM state encoding, default sizing).
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package axis_arb_pkg;

  // Two-state grant FSM: IDLE drives en=0, GRANT drives en=1.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_CHANNEL_NUMBER = 5;
  localparam int DEF_MAX_BEATS      = 256;

endpackage : axis_arb_pkg
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
// Module : rr_select
// Purpose: Combinational round-robin picker. Returns the first set bit of
//          req scanning start, start+1, ... with modulo-N wrap.
// Ports  : req   in  N  request vector, bit i = source i
//          start in  W  scan start position (must be < N)
//          idx   out W  index of the selected request (0 when none)
//          any   out 1  at least one request is set
// Rev    : 1.0  initial release
// ============================================================================
module rr_select #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W:0]   w_sum;
  logic [W-1:0] w_pos;

  // Scan from the farthest offset back to the nearest so the nearest
  // requesting source (relative to start) is the last one written.
  always_comb begin
    idx   = '0;
    any   = |req;
    w_sum = '0;
    w_pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, start} + (W + 1)'(k);
      if (w_sum >= (W + 1)'(N)) begin
        w_sum = w_sum - (W + 1)'(N);
      end
      w_pos = w_sum[W-1:0];
      if (req[w_pos]) begin
        idx = w_pos;
      end
    end
  end

endmodule : rr_select
`default_nettype wire

// File: rtl/axis_if_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axis_if_arbiter
// Purpose: Round-robin packet arbiter controlling a downstream AXI-Stream
//          mux. A grant is held for a whole packet (until TLAST beat) or
//          until MAX_BEATS non-last beats have passed (forced release).
// Ports  : aclk       in  1      clock
//          aresetn    in  1      synchronous active-low reset
//          in_tvalid  in  CHN    per-source TVALID
//          out_tvalid in  1      TVALID at mux output
//          out_tready in  1      TREADY at mux output
//          out_tlast  in  1      TLAST at mux output
//          en         out 1      mux enable (grant held)
//          ctrl       out CHN_W  granted source index
//          overrun    out 1      one-cycle pulse on forced release
// Rev    : 1.0  initial release
// ============================================================================
module axis_if_arbiter
  import axis_arb_pkg::*;
#(
  parameter int CHANNEL_NUMBER       = DEF_CHANNEL_NUMBER,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int MAX_BEATS            = DEF_MAX_BEATS
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [CHANNEL_NUMBER-1:0]       in_tvalid,
  input  logic                            out_tvalid,
  input  logic                            out_tready,
  input  logic                            out_tlast,
  output logic                            en,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl,
  output logic                            overrun
);

  localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);
  localparam logic [CHANNEL_NUMBER_WIDTH-1:0] LAST_CH = CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);

  arb_state_e                      state_q;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl_q;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_q;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_d;
  logic [CNT_W-1:0]                cnt_q;
  logic                            overrun_q;

  logic                            w_beat;
  logic                            w_last_beat;
  logic                            w_limit_hit;
  logic                            w_release;
  logic [CHANNEL_NUMBER_WIDTH-1:0] w_start;
  logic [CHANNEL_NUMBER_WIDTH-1:0] w_pick;
  logic                            w_any;

  assign w_beat      = out_tvalid & out_tready;
  assign w_last_beat = w_beat & out_tlast;
  // A non-last beat arriving with MAX_BEATS-1 already counted is the
  // MAX_BEATS-th beat; a TLAST beat at the same point is a normal release.
  assign w_limit_hit = (MAX_BEATS != 0) && w_beat && !out_tlast && (cnt_q == CNT_LAST);
  assign w_release   = (state_q == GRANT) && (w_last_beat || w_limit_hit);

  assign ptr_d = (ctrl_q == LAST_CH) ? '0 : ctrl_q + 1'b1;

  // On release the next pick must already see the advanced pointer so
  // back-to-back grants need no idle cycle.
  assign w_start = w_release ? ptr_d : ptr_q;

  rr_select #(
    .N (CHANNEL_NUMBER),
    .W (CHANNEL_NUMBER_WIDTH)
  ) u_rr_select (
    .req   (in_tvalid),
    .start (w_start),
    .idx   (w_pick),
    .any   (w_any)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_any) begin
            state_q <= GRANT;
            ctrl_q  <= w_pick;
          end
        end
        GRANT: begin
          if (w_release) begin
            ptr_q     <= ptr_d;
            cnt_q     <= '0;
            overrun_q <= w_limit_hit;
            if (w_any) begin
              ctrl_q <= w_pick;
            end else begin
              state_q <= IDLE;
            end
          end else if (w_beat) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en      = (state_q == GRANT);
  assign ctrl    = ctrl_q;
  assign overrun = overrun_q;

endmodule : axis_if_arbiter
`default_nettype wire

// File: tb/tb_axis_if_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_axis_if_arbiter
// Purpose: Directed scoreboard bench for axis_if_arbiter (5 sources,
//          MAX_BEATS=4). Stimulus pushes the expected post-edge outputs;
//          a monitor pops and compares one entry per clock.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axis_if_arbiter;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [4:0] in_tvalid;
  logic       out_tvalid;
  logic       out_tready;
  logic       out_tlast;
  logic       en;
  logic [2:0] ctrl;
  logic       overrun;

  typedef struct {
    logic       en;
    logic [2:0] ctrl;
    logic       ovr;
    logic       chk_ctrl;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 aclk = ~aclk;

  axis_if_arbiter #(
    .CHANNEL_NUMBER       (5),
    .CHANNEL_NUMBER_WIDTH (3),
    .MAX_BEATS            (4)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_tvalid  (in_tvalid),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast),
    .en         (en),
    .ctrl       (ctrl),
    .overrun    (overrun)
  );

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input string nm, input logic rn, input logic [4:0] tv,
                      input logic v, input logic r, input logic l,
                      input logic ee, input logic [2:0] ec, input logic eo,
                      input logic ck);
    exp_t e;
    @(negedge aclk);
    aresetn    = rn;
    in_tvalid  = tv;
    out_tvalid = v;
    out_tready = r;
    out_tlast  = l;
    e.en       = ee;
    e.ctrl     = ec;
    e.ovr      = eo;
    e.chk_ctrl = ck;
    e.name     = nm;
    sb_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge aclk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (en !== e.en || overrun !== e.ovr || (e.chk_ctrl && ctrl !== e.ctrl)) begin
          n_fail++;
          $display("FAIL %s: got en=%0b ctrl=%0d overrun=%0b, expected en=%0b ctrl=%0d overrun=%0b",
                   e.name, en, ctrl, overrun, e.en, e.ctrl, e.ovr);
        end
      end
    end
  end

  initial begin
    aresetn    = 1'b0;
    in_tvalid  = '0;
    out_tvalid = 1'b0;
    out_tready = 1'b0;
    out_tlast  = 1'b0;

    // Reset state, also with requests and beats present
    step("reset",        0, 5'b00000, 0, 0, 0, 0, 3'd0, 0, 1);
    step("reset_busy",   0, 5'b11111, 1, 1, 0, 0, 3'd0, 0, 1);

    // Single source 2, 3-beat packet, tvalid dropping mid-packet
    step("grant2",       1, 5'b00100, 0, 0, 0, 1, 3'd2, 0, 1);
    step("hold2_b1",     1, 5'b00000, 1, 1, 0, 1, 3'd2, 0, 1);
    step("hold2_b2",     1, 5'b00000, 1, 1, 0, 1, 3'd2, 0, 1);
    step("release2",     1, 5'b00000, 1, 1, 1, 0, 3'd0, 0, 0);
    step("idle_ignore",  1, 5'b00000, 1, 1, 1, 0, 3'd0, 0, 0);

    // All sources, 2-beat packets, rotation 0..4,0 without gaps
    step("rr_reset",     0, 5'b00000, 0, 0, 0, 0, 3'd0, 0, 1);
    step("rr_grant0",    1, 5'b11111, 0, 0, 0, 1, 3'd0, 0, 1);
    for (int c = 0; c < 5; c++) begin
      step("rr_mid",     1, 5'b11111, 1, 1, 0, 1, 3'(c), 0, 1);
      step("rr_next",    1, 5'b11111, 1, 1, 1, 1, 3'((c + 1) % 5), 0, 1);
    end
    step("rr_mid0",      1, 5'b11111, 1, 1, 0, 1, 3'd0, 0, 1);
    step("rr_end",       1, 5'b00000, 1, 1, 1, 0, 3'd0, 0, 0);

    // Backpressured tlast beat (ptr now 1)
    step("bp_grant1",    1, 5'b00010, 0, 0, 0, 1, 3'd1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step("bp_hold",    1, 5'b00000, 1, 0, 1, 1, 3'd1, 0, 1);
    end
    step("bp_release",   1, 5'b00000, 1, 1, 1, 0, 3'd0, 0, 0);

    // Overrun: source 1 streams without tlast, source 3 waiting
    step("ov_reset",     0, 5'b00000, 0, 0, 0, 0, 3'd0, 0, 1);
    step("ov_grant1",    1, 5'b01010, 0, 0, 0, 1, 3'd1, 0, 1);
    step("ov_b1",        1, 5'b01010, 1, 1, 0, 1, 3'd1, 0, 1);
    step("ov_stall",     1, 5'b01010, 1, 0, 0, 1, 3'd1, 0, 1);
    step("ov_b2",        1, 5'b01010, 1, 1, 0, 1, 3'd1, 0, 1);
    step("ov_b3",        1, 5'b01010, 1, 1, 0, 1, 3'd1, 0, 1);
    step("ov_b4_pulse",  1, 5'b01010, 1, 1, 0, 1, 3'd3, 1, 1);
    step("ov_pulse_end", 1, 5'b01010, 0, 0, 0, 1, 3'd3, 0, 1);
    step("ov_rel3",      1, 5'b00000, 1, 1, 1, 0, 3'd0, 0, 0);

    // Grant on 4, tlast on the 4th beat: normal release, wrap to 0
    step("wr_grant4",    1, 5'b10000, 0, 0, 0, 1, 3'd4, 0, 1);
    step("wr_b1",        1, 5'b10000, 1, 1, 0, 1, 3'd4, 0, 1);
    step("wr_b2",        1, 5'b10000, 1, 1, 0, 1, 3'd4, 0, 1);
    step("wr_b3",        1, 5'b10000, 1, 1, 0, 1, 3'd4, 0, 1);
    step("wr_b4_last",   1, 5'b10001, 1, 1, 1, 1, 3'd0, 0, 1);
    step("wr_rel0",      1, 5'b00000, 1, 1, 1, 0, 3'd0, 0, 0);

    // Reset mid-packet on source 3 (ptr now 1)
    step("mr_grant3",    1, 5'b01000, 0, 0, 0, 1, 3'd3, 0, 1);
    step("mr_b1",        1, 5'b01000, 1, 1, 0, 1, 3'd3, 0, 1);
    step("mr_reset",     0, 5'b11111, 1, 1, 0, 0, 3'd0, 0, 1);
    step("mr_grant0",    1, 5'b11111, 0, 0, 0, 1, 3'd0, 0, 1);
    step("mr_idle",      1, 5'b00000, 0, 0, 0, 1, 3'd0, 0, 1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge aclk);
      #2;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_axis_if_arbiter
`default_nettype wire
